// File: rtl/mult_pkg.sv
// mult_pkg: shared state encodings, default width and counter sizing for the shift-add multiplier.
package mult_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/mult_datapath.sv
// mult_datapath: multiplicand register, {carry,upper,lower} shift register and adder (subtractor when SIGNED_MULT_EN).
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic               add,
    input  logic               last,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               lsb
);
    logic [WIDTH-1:0] mcand, upper, lower;
    logic [WIDTH:0]   sum;
`ifdef SIGNED_MULT_EN
    // The multiplier MSB carries weight -2^(WIDTH-1), so the final partial product is subtracted.
    logic [WIDTH:0] up_x, mc_x;
    assign up_x = {upper[WIDTH-1], upper};
    assign mc_x = {mcand[WIDTH-1], mcand};
    always_comb sum = add ? (last ? up_x - mc_x : up_x + mc_x) : up_x;
`else
    logic unused_last;
    assign unused_last = last;
    always_comb sum = add ? {1'b0, upper} + {1'b0, mcand} : {1'b0, upper};
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            upper <= '0;
            lower <= '0;
        end else if (load) begin
            mcand <= a;
            upper <= '0;
            lower <= b;
        end else if (shift) begin
            upper <= sum[WIDTH:1];
            lower <= {sum[0], lower[WIDTH-1:1]};
        end
    end
    assign acc = {upper, lower};
    assign lsb = lower[0];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: radix-2 sequential multiplier, one multiplier bit per clock; SIGNED_MULT_EN selects two's-complement operands.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               valid,
    output logic               busy
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic shift, last, lsb;
    logic [2*WIDTH-1:0] acc;
    assign shift = (state == S_RUN) && !start;
    assign last  = cnt == CW'(WIDTH - 1);
    always_comb begin
        state_n = start ? S_RUN : (state == S_RUN) ? (last ? S_DONE : S_RUN) : (state == S_DONE) ? S_DONE : S_IDLE;
        cnt_n   = start ? '0 : (state == S_RUN) ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .reset(reset),
        .load (start),
        .shift(shift),
        .add  (shift && lsb),
        .last (last),
        .a    (a),
        .b    (b),
        .acc  (acc),
        .lsb  (lsb)
    );
    assign valid   = state == S_DONE;
    assign busy    = state == S_RUN;
    assign product = valid ? acc : '0;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and random checks of shift_add_multiplier against an arithmetic reference multiply.
module tb_shift_add_multiplier;
    logic        clk = 0, reset = 0, start = 0;
    logic [7:0]  a = 0, b = 0;
    logic [15:0] product;
    logic        valid, busy;
    int checks = 0, failures = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .product(product), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef SIGNED_MULT_EN
        logic signed [15:0] sx, sy;
        sx = 16'($signed(x));
        sy = 16'($signed(y));
        return 16'(sx * sy);
`else
        return 16'({8'd0, x} * {8'd0, y});
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] x, input logic [7:0] y);
        start = 1;
        a = x;
        b = y;
        @(negedge clk);
        start = 0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_valid(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!valid && n < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y);
        int n, bn;
        pulse_start(x, y);
        wait_valid(n, bn);
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(bn), 32'd8);
        chk({tag, "_product"}, 32'(product), 32'(ref_mul(x, y)));
    endtask

    initial begin
        int n, bn;
        #2;
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("idle_valid", 32'(valid), 32'd0);

        run_op("f_by_f", 8'h0F, 8'h0F);
        chk("f_by_f_const", 32'(product), 32'h00E1);
        run_op("ff_by_ff", 8'hFF, 8'hFF);
`ifndef SIGNED_MULT_EN
        chk("ff_by_ff_const", 32'(product), 32'hFE01);
`endif
        run_op("zero_a", 8'h00, 8'hA5);
        chk("zero_a_const", 32'(product), 32'h0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_product", 32'(product), 32'h0000);
        end

        pulse_start(8'd3, 8'd5);
        for (int i = 0; i < 3; i++) begin
            chk("restart_no_valid", 32'(valid), 32'd0);
            @(negedge clk);
        end
        pulse_start(8'd7, 8'd9);
        wait_valid(n, bn);
        chk("restart_latency", 32'(n), 32'd8);
        chk("restart_product", 32'(product), 32'h003F);

        pulse_start(8'hAB, 8'hCD);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 0;
        #1;
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("after_reset_busy", 32'(busy), 32'd0);
        run_op("two_by_two", 8'd2, 8'd2);
        chk("two_by_two_const", 32'(product), 32'h0004);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            pulse_start(x, y);
            chk("b2b_valid_drop", 32'(valid), 32'd0);
            wait_valid(n, bn);
            chk("rand_latency", 32'(n), 32'd8);
            chk("rand_product", 32'(product), 32'(ref_mul(x, y)));
        end

        run_op("ff_by_02", 8'hFF, 8'h02);
`ifdef SIGNED_MULT_EN
        chk("ff_by_02_const", 32'(product), 32'hFFFE);
        run_op("m128_sq", 8'h80, 8'h80);
        chk("m128_sq_const", 32'(product), 32'h4000);
`else
        chk("ff_by_02_const", 32'(product), 32'h01FE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
